// File: rtl/bus_datapath_seq_pkg.sv
// Shared types for the bus datapath sequencer: opcode and state encodings,
// plus the operation-width constants used by the top and the ALU.
package bus_datapath_seq_pkg;

  localparam int OPC_W = 3;
  localparam int ST_W  = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_MUL = 3'd6,
    OP_NOT = 3'd7
  } opcode_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_TA   = 3'd1,
    ST_TB   = 3'd2,
    ST_TWL  = 3'd3,
    ST_TWH  = 3'd4
  } state_e;

  function automatic logic is_mul(input opcode_e op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/bus_datapath_seq_alu.sv
// Combinational ALU: Y op B into a double-width Z. Only MUL produces a
// non-zero upper half; shifts use the low log2(WIDTH) bits of B.
module bus_alu
  import bus_datapath_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  opcode_e            op_i,
  input  logic [WIDTH-1:0]   y_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] z_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]     sh_s;
  logic [2*WIDTH-1:0] y_ext_s;
  logic [2*WIDTH-1:0] b_ext_s;
  logic [2*WIDTH-1:0] prod_s;

  // Sign-extend both operands so the truncated product is the signed result.
  assign sh_s    = b_i[SHW-1:0];
  assign y_ext_s = {{WIDTH{y_i[WIDTH-1]}}, y_i};
  assign b_ext_s = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_s  = y_ext_s * b_ext_s;

  // Operation select.
  always_comb begin
    z_o = {(2*WIDTH){1'b0}};
    case (op_i)
      OP_ADD:  z_o[WIDTH-1:0] = y_i + b_i;
      OP_SUB:  z_o[WIDTH-1:0] = y_i - b_i;
      OP_AND:  z_o[WIDTH-1:0] = y_i & b_i;
      OP_OR:   z_o[WIDTH-1:0] = y_i | b_i;
      OP_SHL:  z_o[WIDTH-1:0] = y_i << sh_s;
      OP_SHR:  z_o[WIDTH-1:0] = y_i >> sh_s;
      OP_MUL:  z_o = prod_s;
      OP_NOT:  z_o[WIDTH-1:0] = ~y_i;
      default: z_o = {(2*WIDTH){1'b0}};
    endcase
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus register-file datapath: each operation is micro-sequenced
// over one shared bus (read A, read B + compute, write low, write high).
module bus_datapath_seq
  import bus_datapath_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rd,
  input  logic             imm_en,
  input  logic [WIDTH-1:0] imm,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] bus_contents,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  state_e             state_q;
  opcode_e            op_q;
  logic [AW-1:0]      ra_q;
  logic [AW-1:0]      rb_q;
  logic [AW-1:0]      rd_q;
  logic               imm_en_q;
  logic [WIDTH-1:0]   imm_q;
  logic [WIDTH-1:0]   y_q;
  logic [2*WIDTH-1:0] z_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic [WIDTH-1:0]   regs_q [NREGS];

  logic [WIDTH-1:0]   bus_s;
  logic [WIDTH-1:0]   ra_val_s;
  logic [WIDTH-1:0]   rb_val_s;
  logic [2*WIDTH-1:0] alu_z_s;

  function automatic logic is_r0(input logic [AW-1:0] a);
    return (R0_ZERO != 0) && (a == {AW{1'b0}});
  endfunction

  // Register-file reads; R0 masks to zero when hard-wired.
  always_comb begin
    ra_val_s = is_r0(ra_q)     ? {WIDTH{1'b0}} : regs_q[ra_q];
    rb_val_s = is_r0(rb_q)     ? {WIDTH{1'b0}} : regs_q[rb_q];
    dbg_data = is_r0(dbg_addr) ? {WIDTH{1'b0}} : regs_q[dbg_addr];
  end

  // Bus driver per micro-step; the bus idles at zero.
  always_comb begin
    bus_s = {WIDTH{1'b0}};
    case (state_q)
      ST_IDLE: bus_s = {WIDTH{1'b0}};
      ST_TA:   bus_s = ra_val_s;
      ST_TB:   bus_s = imm_en_q ? imm_q : rb_val_s;
      ST_TWL:  bus_s = z_q[WIDTH-1:0];
      ST_TWH:  bus_s = z_q[2*WIDTH-1:WIDTH];
      default: bus_s = {WIDTH{1'b0}};
    endcase
  end

  bus_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i (op_q),
    .y_i  (y_q),
    .b_i  (bus_s),
    .z_o  (alu_z_s)
  );

  // Sequencer and all datapath state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      ra_q     <= {AW{1'b0}};
      rb_q     <= {AW{1'b0}};
      rd_q     <= {AW{1'b0}};
      imm_en_q <= 1'b0;
      imm_q    <= {WIDTH{1'b0}};
      y_q      <= {WIDTH{1'b0}};
      z_q      <= {(2*WIDTH){1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q     <= opcode_e'(opcode);
            ra_q     <= ra;
            rb_q     <= rb;
            rd_q     <= rd;
            imm_en_q <= imm_en;
            imm_q    <= imm;
            state_q  <= ST_TA;
          end else if (load_en && !is_r0(load_addr)) begin
            regs_q[load_addr] <= load_data;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_TA: begin
          y_q     <= bus_s;
          state_q <= ST_TB;
        end
        ST_TB: begin
          z_q     <= alu_z_s;
          state_q <= ST_TWL;
        end
        ST_TWL: begin
          if (!is_r0(rd_q)) begin
            regs_q[rd_q] <= bus_s;
          end
          lo_q <= bus_s;
          if (is_mul(op_q)) begin
            state_q <= ST_TWH;
          end else begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        ST_TWH: begin
          hi_q    <= bus_s;
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_contents = bus_s;
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench: a 32-bit/16-reg instance for sequencing, MUL, R0 and
// reset behaviour, and a 16-bit/8-reg instance for shift boundaries.
module tb_bus_datapath_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 32-bit instance signals
  logic        a_clr, a_start, a_imm_en, a_load_en, a_busy, a_done;
  logic [2:0]  a_opcode;
  logic [3:0]  a_ra, a_rb, a_rd, a_load_addr, a_dbg_addr;
  logic [31:0] a_imm, a_load_data, a_dbg_data, a_bus, a_hi, a_lo;

  // 16-bit instance signals
  logic        b_clr, b_start, b_imm_en, b_load_en, b_busy, b_done;
  logic [2:0]  b_opcode;
  logic [2:0]  b_ra, b_rb, b_rd, b_load_addr, b_dbg_addr;
  logic [15:0] b_imm, b_load_data, b_dbg_data, b_bus, b_hi, b_lo;

  int nb;

  bus_datapath_seq #(.WIDTH(32), .NREGS(16), .R0_ZERO(1)) dut32 (
    .clk(clk), .clr(a_clr), .start(a_start), .opcode(a_opcode),
    .ra(a_ra), .rb(a_rb), .rd(a_rd), .imm_en(a_imm_en), .imm(a_imm),
    .load_en(a_load_en), .load_addr(a_load_addr), .load_data(a_load_data),
    .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data), .bus_contents(a_bus),
    .hi_out(a_hi), .lo_out(a_lo), .busy(a_busy), .done(a_done)
  );

  bus_datapath_seq #(.WIDTH(16), .NREGS(8), .R0_ZERO(1)) dut16 (
    .clk(clk), .clr(b_clr), .start(b_start), .opcode(b_opcode),
    .ra(b_ra), .rb(b_rb), .rd(b_rd), .imm_en(b_imm_en), .imm(b_imm),
    .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data),
    .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data), .bus_contents(b_bus),
    .hi_out(b_hi), .lo_out(b_lo), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load32(input logic [3:0] addr, input logic [31:0] data);
    a_load_en = 1'b1; a_load_addr = addr; a_load_data = data;
    @(negedge clk);
    a_load_en = 1'b0;
  endtask

  task automatic rd32(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    a_dbg_addr = addr;
    #1;
    chk(tag, {32'd0, a_dbg_data}, {32'd0, exp});
  endtask

  // Issue one operation, scramble inputs after accept, count busy cycles,
  // check the done pulse. With ld set, load_en stays high through start and busy.
  task automatic op32(input logic [2:0] op, input logic [3:0] ra_v, rb_v, rd_v,
                      input logic ie, input logic [31:0] im, input logic ld,
                      output int nbusy);
    a_opcode = op; a_ra = ra_v; a_rb = rb_v; a_rd = rd_v;
    a_imm_en = ie; a_imm = im; a_start = 1'b1;
    if (ld) begin
      a_load_en = 1'b1; a_load_addr = 4'd10; a_load_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    a_start = 1'b0; a_opcode = 3'd2; a_ra = 4'd15; a_rb = 4'd15; a_rd = 4'd15;
    a_imm_en = ~ie; a_imm = 32'h5A5A_5A5A;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_busy) begin
        chk("done_low_while_busy", {63'd0, a_done}, 64'd0);
        nbusy++;
        @(negedge clk);
      end
    end
    a_load_en = 1'b0;
    chk("done_pulse", {63'd0, a_done}, 64'd1);
    @(negedge clk);
    chk("done_single", {63'd0, a_done}, 64'd0);
  endtask

  task automatic op16(input logic [2:0] op, input logic [2:0] ra_v, rd_v,
                      input logic [15:0] im, output int nbusy);
    b_opcode = op; b_ra = ra_v; b_rb = 3'd0; b_rd = rd_v;
    b_imm_en = 1'b1; b_imm = im; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; b_imm = 16'h0007;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      if (b_busy) begin
        nbusy++;
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    a_clr = 1'b0; a_start = 1'b0; a_imm_en = 1'b0; a_load_en = 1'b0;
    a_opcode = 3'd0; a_ra = 4'd0; a_rb = 4'd0; a_rd = 4'd0;
    a_load_addr = 4'd0; a_dbg_addr = 4'd0; a_imm = 32'd0; a_load_data = 32'd0;
    b_clr = 1'b0; b_start = 1'b0; b_imm_en = 1'b0; b_load_en = 1'b0;
    b_opcode = 3'd0; b_ra = 3'd0; b_rb = 3'd0; b_rd = 3'd0;
    b_load_addr = 3'd0; b_dbg_addr = 3'd0; b_imm = 16'd0; b_load_data = 16'd0;

    #1;
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_done", {63'd0, a_done}, 64'd0);
    chk("rst_bus",  {32'd0, a_bus},  64'd0);
    chk("rst_hi",   {32'd0, a_hi},   64'd0);
    @(negedge clk);
    a_clr = 1'b1; b_clr = 1'b1;
    @(negedge clk);

    load32(4'd1, 32'd5);
    load32(4'd2, 32'd7);
    rd32("load_r1", 4'd1, 32'd5);

    // ADD with mid-operation input scrambling
    op32(3'd0, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, 1'b0, nb);
    chk("add_busy_cycles", 64'(nb), 64'd3);
    rd32("add_r3", 4'd3, 32'd12);
    chk("add_lo", {32'd0, a_lo}, 64'd12);

    // ra = rb = rd uses the pre-write value
    op32(3'd0, 4'd3, 4'd3, 4'd3, 1'b0, 32'd0, 1'b0, nb);
    rd32("alias_r3", 4'd3, 32'd24);

    // signed MUL: -3 * 4
    load32(4'd6, 32'hFFFF_FFFD);
    load32(4'd7, 32'd4);
    op32(3'd6, 4'd6, 4'd7, 4'd8, 1'b0, 32'd0, 1'b0, nb);
    chk("mul_busy_cycles", 64'(nb), 64'd4);
    rd32("mul_lo_reg", 4'd8, 32'hFFFF_FFF4);
    chk("mul_hi", {32'd0, a_hi}, {32'd0, 32'hFFFF_FFFF});
    chk("mul_lo", {32'd0, a_lo}, {32'd0, 32'hFFFF_FFF4});

    // SUB 0 - imm 1 wraps; HI untouched by non-MUL ops
    op32(3'd1, 4'd5, 4'd0, 4'd4, 1'b1, 32'd1, 1'b0, nb);
    chk("sub_busy_cycles", 64'(nb), 64'd3);
    rd32("sub_r4", 4'd4, 32'hFFFF_FFFF);
    chk("sub_hi_kept", {32'd0, a_hi}, {32'd0, 32'hFFFF_FFFF});

    op32(3'd7, 4'd1, 4'd0, 4'd9, 1'b0, 32'd0, 1'b0, nb);
    rd32("not_r9", 4'd9, 32'hFFFF_FFFA);
    op32(3'd3, 4'd1, 4'd0, 4'd11, 1'b1, 32'h0000_00F0, 1'b0, nb);
    rd32("or_imm_r11", 4'd11, 32'h0000_00F5);
    op32(3'd2, 4'd9, 4'd7, 4'd12, 1'b0, 32'd0, 1'b0, nb);
    rd32("and_r12", 4'd12, 32'h0000_0000);

    // R0 target plus loads attempted with start and during busy
    op32(3'd0, 4'd1, 4'd2, 4'd0, 1'b0, 32'd0, 1'b1, nb);
    rd32("r0_rd_write", 4'd0, 32'd0);
    rd32("load_busy_dropped", 4'd10, 32'd0);
    chk("r0_lo_written", {32'd0, a_lo}, 64'd12);
    load32(4'd0, 32'h1234);
    rd32("r0_load_write", 4'd0, 32'd0);

    // clr asserted during TB
    a_opcode = 3'd0; a_ra = 4'd1; a_rb = 4'd2; a_rd = 4'd13; a_imm_en = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("abort_ta_bus", {32'd0, a_bus}, 64'd5);
    @(negedge clk);
    chk("abort_tb_bus", {32'd0, a_bus}, 64'd7);
    a_clr = 1'b0;
    #1;
    chk("abort_busy", {63'd0, a_busy}, 64'd0);
    chk("abort_done", {63'd0, a_done}, 64'd0);
    chk("abort_bus",  {32'd0, a_bus},  64'd0);
    chk("abort_hi",   {32'd0, a_hi},   64'd0);
    chk("abort_lo",   {32'd0, a_lo},   64'd0);
    rd32("abort_r1_cleared", 4'd1, 32'd0);
    @(negedge clk);
    a_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", {62'd0, a_done, a_busy}, 64'd0);
    end
    rd32("abort_r13", 4'd13, 32'd0);

    // 16-bit shifts at the shift-amount boundary
    b_load_en = 1'b1; b_load_addr = 3'd1; b_load_data = 16'h0001;
    @(negedge clk);
    b_load_en = 1'b0;
    op16(3'd4, 3'd1, 3'd2, 16'd15, nb);
    chk("shl16_busy_cycles", 64'(nb), 64'd3);
    b_dbg_addr = 3'd2; #1;
    chk("shl16_by15", {48'd0, b_dbg_data}, 64'h8000);
    op16(3'd5, 3'd1, 3'd3, 16'd16, nb);
    b_dbg_addr = 3'd3; #1;
    chk("shr16_by16", {48'd0, b_dbg_data}, 64'h0001);
    op16(3'd5, 3'd2, 3'd4, 16'd3, nb);
    b_dbg_addr = 3'd4; #1;
    chk("shr16_logical", {48'd0, b_dbg_data}, 64'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_datapath_seq.md
BUS_DATAPATH_SEQ -- requirements
Module: bus_datapath_seq

Interface
REQ-001 Parameter WIDTH, default 32: datapath/bus width in bits (>= 8).
REQ-002 Parameter NREGS, default 16: general register count (power of two, >= 4); AW = log2(NREGS).
REQ-003 Parameter R0_ZERO, default 1: when 1, R0 reads as zero and ignores writes.
REQ-004 Clocking: one clock, clk; reset clr is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 clr  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request one micro-sequenced operation; sampled only in IDLE.
REQ-008 opcode  in  3  ADD=0, SUB=1, AND=2, OR=3, SHL=4, SHR=5, MUL=6, NOT=7.
REQ-009 ra, rb, rd  in  AW each  source A, source B and destination register indices.
REQ-010 imm_en  in  1  when 1, imm replaces R[rb] as operand B.
REQ-011 imm  in  WIDTH  immediate operand.
REQ-012 load_en, load_addr, load_data  in  1/AW/WIDTH  external register write port.
REQ-013 dbg_addr  in  AW; dbg_data  out  WIDTH  combinational read of R[dbg_addr].
REQ-014 bus_contents  out  WIDTH  current internal bus value (zero in IDLE).
REQ-015 hi_out, lo_out  out  WIDTH each  HI register and R[rd]-written Z-low copy (LO).
REQ-016 busy  out  1; done  out  1  one-cycle completion pulse.

Function
REQ-017 States IDLE, TA, TB, TWL, TWH; IDLE->TA on start; TA->TB->TWL always; TWL->TWH if MUL else IDLE; TWH->IDLE.
REQ-018 opcode, ra, rb, rd, imm_en, imm captured at the start-accept edge; later input changes do not affect the operation.
REQ-019 TA: bus = R[ra]; Y <= bus.
REQ-020 TB: bus = imm_en ? imm : R[rb]; Z (2*WIDTH) <= ALU(Y, bus).
REQ-021 TWL: bus = Z[WIDTH-1:0]; R[rd] <= bus; LO <= bus.
REQ-022 TWH (MUL only): bus = Z[2W-1:W]; HI <= bus.
REQ-023 ALU: ADD/SUB modulo 2^WIDTH; AND/OR/NOT(Y) bitwise; SHL/SHR logical by bus[log2(WIDTH)-1:0]; MUL signed WIDTH x WIDTH -> 2*WIDTH; Z high = 0 for all non-MUL ops.
REQ-024 Latency: result in R[rd] after edge 3 following accept (edge 4 for HI on MUL); done = 1 during the cycle after the final write edge.
REQ-025 busy = 1 in TA, TB, TWL, TWH; start while busy ignored.
REQ-026 load_en in IDLE with start = 0 writes R[load_addr] at the edge; load_en while busy or simultaneous with start is dropped.
REQ-027 R0_ZERO = 1: writes to R0 (rd or load_addr) discarded; R0 operand reads 0.
REQ-028 ra = rb = rd permitted; TB reads pre-write value.

Reset
REQ-029 clr low: state IDLE, all R, Y, Z, HI, LO = 0, busy = 0, done = 0, immediately and independent of clk.
REQ-030 clr asserted mid-operation abandons it; no register write and no done pulse follow.

Structure
REQ-031 Shared package holds opcode enum, state enum and op-width constants.
REQ-032 ALU is a separate combinational sub-module, bus_alu, parametrised on WIDTH.

Verification
REQ-033 Load R1=5, R2=7; ADD ra=1 rb=2 rd=3 -> R3=12 after 3 edges, done single pulse, busy 3 cycles.
REQ-034 SUB R1=0, imm_en=1 imm=1, rd=4 -> R4=0xFFFFFFFF (WIDTH 32), HI unchanged.
REQ-035 MUL R1=-3, R2=4 -> R[rd]=0xFFFFFFF4, HI=0xFFFFFFFF, busy 4 cycles.
REQ-036 Start with rd=0, R0_ZERO=1 -> R0 remains 0; load_en during busy -> no register change.
REQ-037 clr low during TB -> all outputs 0 at once; after release R[rd] unchanged, no done.
REQ-038 WIDTH=16, NREGS=8: SHL R1=0x0001 by imm=15 -> 0x8000; SHR by imm=16 -> shift 0, result 0x0001.
